mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares one word-wide data RAM (combinational read, single-cycle write) between the CPU instruction-fetch port and data port. Each master uses a waitrequest-style bus. The block arbitrates round-robin, inserts programmable wait states, and turns partial-byte writes into read-modify-write. It sits between the MIPS core bus ports and the RAM model in the testbench memory subsystem.

## Interface
- WAIT_STATES, default 1: extra stall cycles inserted before each RAM access; legal range 0..7.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  32  instruction master byte address; bits [1:0] ignored.
- m0_read  in  1  instruction read request.
- m0_readdata  out  32  instruction read data.
- m0_waitrequest  out  1  instruction master stall.
- m1_address  in  32  data master byte address; bits [1:0] ignored.
- m1_read  in  1  data read request.
- m1_write  in  1  data write request.
- m1_byteenable  in  4  write lane enables; bit k selects writedata[8k+7:8k].
- m1_writedata  in  32  data write data.
- m1_readdata  out  32  data read data.
- m1_waitrequest  out  1  data master stall.
- ram_address  out  32  RAM byte address, always {addr[31:2],2'b00}.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe; the RAM writes on this clk edge.
- ram_writedata  out  32  RAM write word.
- ram_readdata  in  32  RAM combinational read word.

## Operation
- States: IDLE, WAIT, ACCESS, MERGE.
- Request definitions: req0 = m0_read; req1 = m1_read | m1_write. If m1_read and m1_write are both high, the request is treated as a write.
- IDLE with any request:
  - Grant m0 or m1; on contention, grant the master not granted last.
  - last_grant resets to m1, so m0 wins the first tie.
  - Latch address, read/write kind, byteenable and writedata.
  - Go to WAIT with counter = WAIT_STATES. If WAIT_STATES = 0, go directly to ACCESS.
- WAIT: decrement the counter. Go to ACCESS on the cycle it reaches 1.
- ACCESS, read: ram_read = 1; granted readdata = ram_readdata passed through combinationally; waitrequest low; then IDLE.
- ACCESS, write with byteenable = 1111: ram_write = 1; ram_writedata = latched data; waitrequest low; then IDLE.
- ACCESS, write with byteenable = 0000: no RAM strobe; waitrequest low; then IDLE.
- ACCESS, any other write (partial):
  - ram_read = 1.
  - Latch merged word: enabled lanes from writedata, other lanes from ram_readdata.
  - waitrequest stays high; go to MERGE.
- MERGE: ram_write = 1 with the merged word; waitrequest low; then IDLE.
- Byte lanes are passed through unchanged. No endian swap is performed; the RAM owns byte ordering.
- mN_waitrequest = reqN & ~(granted to N & completion cycle).
  - It is low whenever that master is not requesting.
  - A non-granted requester stays stalled.
- mN_readdata outside that master's completion cycle: holds the last word returned to that master. Reset value 32'h0.
- RAM outputs when not in ACCESS/MERGE: ram_read = 0, ram_write = 0, ram_address and ram_writedata = latched values.
- Masters must hold request signals stable while stalled. Changes after grant are ignored because the latched copies are used.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE; counter cleared; last_grant = m1; readdata registers = 0; ram_read = ram_write = 0.
  - A transaction interrupted by reset is abandoned. No RAM write occurs unless ram_write was already high at a preceding clk edge.
- Latency, with request first seen in IDLE at cycle 0:
  - Read or full write completes (waitrequest low) in cycle WAIT_STATES+1.
  - Partial write completes in cycle WAIT_STATES+2.
- Throughput: the cycle after completion is IDLE and can grant immediately. Back-to-back reads take WAIT_STATES+2 cycles each.
- Contention: a losing master's request is granted in the IDLE cycle following the winner's completion, if still asserted.
- Merged word is captured at the ACCESS edge. Any RAM change during MERGE is impossible because this block is the sole writer.

## Test plan
- Read, no contention (WAIT_STATES = 1, RAM[0x10] = 32'h11223344): m1 read 0x10 -> m1_waitrequest high at cycles 0–1, low at cycle 2 with m1_readdata = 32'h11223344; value held afterwards.
- Full write then read: m1 write 0x20, data 32'hDEADBEEF, be = 1111 -> a single ram_write at cycle 2; a subsequent read returns 32'hDEADBEEF.
- Partial write (RAM[0x30] = 32'hAABBCCDD): be = 0101, data 32'h11223344 -> ram_read at cycle 2, ram_write at cycle 3 with 32'hAA22CC44; waitrequest low only at cycle 3.
- Contention: m0 and m1 both request at reset release -> m0 served first; m1 completes at cycle 5 (WAIT_STATES = 1). Repeating the tie grants m1 first.
- Reset mid-write: assert reset during WAIT of a 32'hCAFEF00D write to 0x40 -> RAM[0x40] is unchanged; outputs show their reset values; the next request is served normally.
- WAIT_STATES = 0: m0 read completes at cycle 1; byteenable = 0000 write completes at cycle 1 with no ram_write pulse.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Lets the CPU instruction-fetch master (m0) and data master (m1) share one
// word-wide RAM. The RAM has a combinational read and writes on the clock edge
// where ram_write is high.
//
// Behaviour:
//   - Round-robin arbitration. On a tie, the master not granted last time wins.
//   - WAIT_STATES stall cycles (0..7) are inserted before every RAM access.
//   - A write with a partial byteenable becomes a read-modify-write.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   m0_*              instruction master: read-only, waitrequest-style
//   m1_*              data master: read/write with byteenable, waitrequest-style
//   ram_*             RAM side: word-aligned address, read/write strobes, data
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] ram_address,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_MERGE
    } state_t;

    state_t      state_reg,      state_next;
    logic [2:0]  cnt_reg,        cnt_next;
    logic        last_grant_reg, last_grant_next;   // 0 = m0, 1 = m1
    logic        grant_reg,      grant_next;
    logic [29:0] addr_reg,       addr_next;         // word address
    logic        write_reg,      write_next;
    logic [3:0]  be_reg,         be_next;
    logic [31:0] wdata_reg,      wdata_next;
    logic [31:0] merged_reg,     merged_next;
    logic [31:0] rdata0_reg,     rdata0_next;
    logic [31:0] rdata1_reg,     rdata1_next;

    logic        req0;
    logic        req1;
    logic        grant_sel;
    logic        done0;
    logic        done1;
    logic [31:0] merge_word;

    // Byte offset bits are never used: the RAM is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_address[1:0], m1_address[1:0]};

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

    // Build the read-modify-write word lane by lane.
    // Enabled lanes come from the latched write data.
    // The other lanes come from the current RAM word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
            assign merge_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                                      : ram_readdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 3'd0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            addr_reg       <= 30'd0;
            write_reg      <= 1'b0;
            be_reg         <= 4'd0;
            wdata_reg      <= 32'd0;
            merged_reg     <= 32'd0;
            rdata0_reg     <= 32'd0;
            rdata1_reg     <= 32'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            addr_reg       <= addr_next;
            write_reg      <= write_next;
            be_reg         <= be_next;
            wdata_reg      <= wdata_next;
            merged_reg     <= merged_next;
            rdata0_reg     <= rdata0_next;
            rdata1_reg     <= rdata1_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        addr_next       = addr_reg;
        write_next      = write_reg;
        be_next         = be_reg;
        wdata_next      = wdata_reg;
        merged_next     = merged_reg;
        rdata0_next     = rdata0_reg;
        rdata1_next     = rdata1_reg;
        grant_sel       = 1'b0;
        done0           = 1'b0;
        done1           = 1'b0;
        ram_read        = 1'b0;
        ram_write       = 1'b0;
        ram_address     = {addr_reg, 2'b00};
        ram_writedata   = wdata_reg;
        m0_readdata     = rdata0_reg;
        m1_readdata     = rdata1_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req0 | req1) begin
                    // On a tie, the master granted last time loses.
                    // A lone requester always wins.
                    grant_sel       = (req0 & req1) ? ~last_grant_reg : req1;
                    grant_next      = grant_sel;
                    last_grant_next = grant_sel;
                    if (grant_sel) begin
                        addr_next  = m1_address[31:2];
                        write_next = m1_write;        // read+write counts as a write
                        be_next    = m1_byteenable;
                        wdata_next = m1_writedata;
                    end else begin
                        addr_next  = m0_address[31:2];
                        write_next = 1'b0;
                        be_next    = 4'd0;
                        wdata_next = 32'd0;
                    end
                    cnt_next   = WS;
                    state_next = (WS == 3'd0) ? ST_ACCESS : ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The counter counts down from WS to 1.
                // This gives exactly WS stall cycles.
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    cnt_next   = 3'd0;
                    state_next = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                state_next = ST_IDLE;
                if (!write_reg) begin
                    ram_read = 1'b1;
                    done0    = ~grant_reg;
                    done1    = grant_reg;
                    if (grant_reg) begin
                        m1_readdata = ram_readdata;
                        rdata1_next = ram_readdata;
                    end else begin
                        m0_readdata = ram_readdata;
                        rdata0_next = ram_readdata;
                    end
                end else if (be_reg == 4'b1111) begin
                    ram_write = 1'b1;
                    done0     = ~grant_reg;
                    done1     = grant_reg;
                end else if (be_reg == 4'b0000) begin
                    // Nothing to write: complete without touching the RAM.
                    done0 = ~grant_reg;
                    done1 = grant_reg;
                end else begin
                    // Partial write: capture the merged word now.
                    // MERGE then writes it back.
                    ram_read    = 1'b1;
                    merged_next = merge_word;
                    state_next  = ST_MERGE;
                end
            end

            ST_MERGE: begin
                ram_write     = 1'b1;
                ram_writedata = merged_reg;
                done0         = ~grant_reg;
                done1         = grant_reg;
                state_next    = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Each master is stalled while it requests.
    // The stall drops only in its own completion cycle.
    assign m0_waitrequest = req0 & ~done0;
    assign m1_waitrequest = req1 & ~done1;

endmodule
